ring_counter_gen: RTL and testbench
===================================

Name: ring_counter_gen

Overview:
Parametrised successor to the fixed single-output ring counter: an N-bit shift-register sequencer with selectable ring (one-hot) or Johnson (twisted-ring) mode, up/down direction, clock enable, parallel load and a terminal-count pulse. It is used as a phase/slot generator for multi-phase clocking and time-division control. The full state vector is exposed, and the wrap point is flagged explicitly.

Parameters:
N, 8, state width in bits; legal range N >= 2. Period is N cycles in ring mode and 2N cycles in Johnson mode.

Ports:
CK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high; sampled on CK rising edge
EN  input  1  step enable; 1 advances one state per cycle
MODE  input  1  0 = ring (one-hot), 1 = Johnson
DIR  input  1  0 = shift toward MSB (up), 1 = shift toward LSB (down)
LOAD  input  1  parallel load strobe
LOAD_VAL  input  N  value written to Q on LOAD
Q  output  N  registered state vector
TC  output  1  registered terminal-count pulse

Behaviour:
- Interface fixed: one clock CK; reset RST is synchronous and active-high.
- Home pattern H(MODE):
  - Ring: Q = 1 (bit0 set only).
  - Johnson: Q = 0.
- Reset: when RST=1 at a CK edge:
  - Q <= H(MODE_in), TC <= 0, internal mode_q <= MODE.
  - RST overrides every other input.
- Priority per edge: RST > mode change > LOAD > EN step > hold.
- Mode change: the block registers MODE into mode_q every cycle. If MODE != mode_q (and RST=0):
  - Q <= H(MODE), TC <= 0.
  - LOAD and EN are ignored that cycle.
- LOAD=1: Q <= LOAD_VAL, TC <= 0, regardless of EN.
- EN=1 step, next-state rules:
  - Ring up: Q <= {Q[N-2:0], Q[N-1]}
  - Ring down: Q <= {Q[0], Q[N-1:1]}
  - Johnson up: Q <= {Q[N-2:0], ~Q[N-1]}
  - Johnson down: Q <= {~Q[0], Q[N-1:1]}
- TC on a step: TC <= 1 if the next Q equals H(mode_q), else 0. TC is high in the same cycle Q shows home.
- EN=0 with no higher-priority event: Q holds, TC <= 0. TC never stays high more than one cycle.
- Period with EN held high:
  - Ring: TC once every N cycles.
  - Johnson: TC once every 2N cycles.
- DIR change mid-sequence takes effect on the next step; there is no resynchronisation. The sequence reverses from the current Q.
- Illegal states: the block does not correct them (macro off). Examples: ring with popcount != 1; Johnson with more than one adjacent-bit transition. They shift per the rules above. Ring Q=0 stays at 0 forever, with TC never set.
- Latency: each input acts on Q/TC at the first CK edge at which it is sampled. There is no combinational input-to-output path.

Optional Feature:
RING_ERR_DET_EN
- Defined:
  - Adds output port ERR (1 bit, reset 0).
  - On an EN step, Q is checked for legality under mode_q:
    - Ring legal: exactly one bit set.
    - Johnson legal: at most one i in 0..N-2 with Q[i] != Q[i+1].
  - If Q is illegal: Q <= H(mode_q) instead of the shifted value, TC <= 0, ERR <= 1 for one cycle.
  - LOAD of an illegal value is accepted as-is; it is caught at the next EN step.
  - ERR <= 0 on every other cycle, and on RST, LOAD and mode change.
- Undefined: no ERR port, no check, behaviour exactly as in Behaviour.

Test Plan:
- Reset, N=4, MODE=0, DIR=0, RST=1 then EN=1 for 8 cycles -> Q: 0001 after reset, then 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001. TC=1 only when Q=0001 after a step (every 4th cycle).
- N=4, MODE=1, DIR=1, EN=1 from reset -> Q: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. TC=1 on the return to 0000 only (period 8).
- LOAD and EN together, N=4, ring: LOAD=1, EN=1, LOAD_VAL=0100 -> Q=0100, TC=0. Next EN step gives 1000. Then toggle EN 1/0/1 -> Q holds during EN=0 and TC stays 0.
- Mode change mid-operation: ring Q=0100, set MODE=1 with LOAD=1 and EN=1 -> Q=0000, TC=0, load ignored. Next EN step gives 0001.
- RST during a step with LOAD=1 (Johnson, Q=1110) -> Q=0000, TC=0. Direction flip at ring Q=0100 from up to down -> next Q=0010.
- Macro on, N=4, ring: LOAD_VAL=0110 then EN=1 -> Q=0001, ERR=1 for one cycle, TC=0. Next step gives Q=0010, ERR=0. Macro off, same stimulus -> Q=1100.

Source files
------------

// File: rtl/ring_counter_if.sv
// Bus bundle for ring_counter_gen: step/load controls in, state vector and terminal count out.
// ERR is present only when RING_ERR_DET_EN is defined.
interface ring_counter_if #(
    parameter int N = 8
);
    logic         EN;
    logic         MODE;
    logic         DIR;
    logic         LOAD;
    logic [N-1:0] LOAD_VAL;
    logic [N-1:0] Q;
    logic         TC;
`ifdef RING_ERR_DET_EN
    logic         ERR;
`endif

    modport master (
        output EN, MODE, DIR, LOAD, LOAD_VAL,
`ifdef RING_ERR_DET_EN
        input  ERR,
`endif
        input  Q, TC
    );

    modport slave (
        input  EN, MODE, DIR, LOAD, LOAD_VAL,
`ifdef RING_ERR_DET_EN
        output ERR,
`endif
        output Q, TC
    );
endinterface

// File: rtl/ring_counter_gen.sv
// N-bit ring / Johnson sequencer with up/down stepping, parallel load and terminal-count pulse.
// Optional illegal-state detection and recovery is enabled by defining RING_ERR_DET_EN.
module ring_counter_gen #(
    parameter int N = 8
) (
    input logic          CK,
    input logic          RST,
    ring_counter_if.slave bus
);
    logic         mode_q;
    logic [N-1:0] home_cur;
    logic [N-1:0] home_new;
    logic [N-1:0] step_q;
`ifdef RING_ERR_DET_EN
    logic         illegal;
`endif

    function automatic logic [N-1:0] home_of(input logic johnson);
        return johnson ? '0 : {{(N-1){1'b0}}, 1'b1};
    endfunction

    // The Johnson twist is just an inverted feedback bit, so both modes share one shifter.
    function automatic logic [N-1:0] shift_of(input logic [N-1:0] q,
                                              input logic       johnson,
                                              input logic       down);
        logic fb;
        if (down) begin
            fb = q[0] ^ johnson;
            return {fb, q[N-1:1]};
        end
        fb = q[N-1] ^ johnson;
        return {q[N-2:0], fb};
    endfunction

`ifdef RING_ERR_DET_EN
    function automatic logic is_legal(input logic [N-1:0] q, input logic johnson);
        if (johnson)
            return $countones(q[N-2:0] ^ q[N-1:1]) <= 1;
        return $countones(q) == 1;
    endfunction
`endif

    always_comb begin
        home_cur = home_of(mode_q);
        home_new = home_of(bus.MODE);
        step_q   = shift_of(bus.Q, mode_q, bus.DIR);
`ifdef RING_ERR_DET_EN
        illegal  = !is_legal(bus.Q, mode_q);
`endif
    end

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking would let mode_q's update leak into the compare below.
    always_ff @(posedge CK) begin
        mode_q <= bus.MODE;
`ifdef RING_ERR_DET_EN
        bus.ERR <= 1'b0;
`endif
        if (RST) begin
            bus.Q  <= home_new;
            bus.TC <= 1'b0;
        end else if (bus.MODE != mode_q) begin
            bus.Q  <= home_new;
            bus.TC <= 1'b0;
        end else if (bus.LOAD) begin
            bus.Q  <= bus.LOAD_VAL;
            bus.TC <= 1'b0;
        end else if (bus.EN) begin
`ifdef RING_ERR_DET_EN
            if (illegal) begin
                bus.Q   <= home_cur;
                bus.TC  <= 1'b0;
                bus.ERR <= 1'b1;
            end else
`endif
            begin
                bus.Q  <= step_q;
                bus.TC <= (step_q == home_cur);
            end
        end else begin
            bus.TC <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ring_counter_gen.sv
// Self-checking bench for ring_counter_gen (N=4): directed vector table, corner sequences,
// and randomized stimulus against an arithmetic reference model. Honors RING_ERR_DET_EN.
module tb_ring_counter_gen;
    localparam int NB = 4;

    typedef struct {
        logic          rst;
        logic          en;
        logic          mode;
        logic          dir;
        logic          load;
        logic [NB-1:0] lv;
        logic [NB-1:0] exp_q;
        logic          exp_tc;
        string         name;
    } vec_t;

    logic CK;
    logic RST;
    int   n_cmp;
    int   n_fail;

    ring_counter_if #(.N(NB)) bus ();

    ring_counter_gen #(.N(NB)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CK = ~CK;

    // reference model state
    logic [NB-1:0] m_q;
    logic          m_tc;
    logic          m_err;
    logic          m_mode;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic mode, input logic dir,
                         input logic load, input logic [NB-1:0] lv);
        @(negedge CK);
        RST          = rst;
        bus.EN       = en;
        bus.MODE     = mode;
        bus.DIR      = dir;
        bus.LOAD     = load;
        bus.LOAD_VAL = lv;
        @(posedge CK);
        #1;
    endtask

    task automatic check_err(input string name, input logic exp);
`ifdef RING_ERR_DET_EN
        check({name, ".err"}, {31'd0, bus.ERR}, {31'd0, exp});
`else
        if (exp) $display("note: %s expects ERR without detector", name);
`endif
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic mode, input logic dir,
                                input logic load, input logic [NB-1:0] lv,
                                input logic [NB-1:0] eq, input logic etc, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.mode = mode; v.dir = dir; v.load = load; v.lv = lv;
        v.exp_q = eq; v.exp_tc = etc; v.name = name;
        return v;
    endfunction

    // Reference: rotation/twist computed with integer arithmetic from the sequencing rules.
    task automatic model_step(input logic rst, input logic en, input logic mode, input logic dir,
                              input logic load, input logic [NB-1:0] lv);
        int q, nxt, home, fb, ones, trans;
        bit legal;
        q    = int'(m_q);
        home = m_mode ? 0 : 1;
        m_err = 1'b0;
        if (rst || mode != m_mode) begin
            m_q  = mode ? '0 : NB'(1);
            m_tc = 1'b0;
        end else if (load) begin
            m_q  = lv;
            m_tc = 1'b0;
        end else if (en) begin
            ones = 0;
            trans = 0;
            for (int i = 0; i < NB; i++) ones += (q >> i) & 1;
            for (int i = 0; i < NB - 1; i++) trans += ((q >> i) & 1) != ((q >> (i + 1)) & 1);
            legal = m_mode ? (trans <= 1) : (ones == 1);
`ifndef RING_ERR_DET_EN
            legal = 1'b1;
`endif
            if (!legal) begin
                m_q   = NB'(home);
                m_tc  = 1'b0;
                m_err = 1'b1;
            end else begin
                if (!dir) begin
                    fb  = (q >> (NB - 1)) & 1;
                    if (m_mode) fb = 1 - fb;
                    nxt = (q * 2) % (1 << NB) + fb;
                end else begin
                    fb  = q & 1;
                    if (m_mode) fb = 1 - fb;
                    nxt = q / 2 + fb * (1 << (NB - 1));
                end
                m_q  = NB'(nxt);
                m_tc = (nxt == home);
            end
        end else begin
            m_tc = 1'b0;
        end
        m_mode = mode;
    endtask

    initial begin
        vec_t vecs[$];
        int   tc_count;
        int   last_tc;
        logic r_rst, r_en, r_mode, r_dir, r_load;
        logic [NB-1:0] r_lv;

        n_cmp = 0;
        n_fail = 0;
        CK = 1'b0;
        RST = 1'b1;
        bus.EN = 1'b0;
        bus.MODE = 1'b0;
        bus.DIR = 1'b0;
        bus.LOAD = 1'b0;
        bus.LOAD_VAL = '0;

        // ring up from reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, "ring_reset"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 0, "ring_up1"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0100, 0, "ring_up2"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, "ring_up3"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, "ring_up4_tc"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 0, "ring_up5"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0100, 0, "ring_up6"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, "ring_up7"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, "ring_up8_tc"));
        // Johnson down from reset
        vecs.push_back(mk(1, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, "john_reset"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b1000, 0, "john_dn1"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b1100, 0, "john_dn2"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b1110, 0, "john_dn3"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b1111, 0, "john_dn4"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b0111, 0, "john_dn5"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b0011, 0, "john_dn6"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b0001, 0, "john_dn7"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b0000, 4'b0000, 1, "john_dn8_tc"));
        // load beats enable, then hold behaviour
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, "ld_reset"));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0100, 4'b0100, 0, "ld_with_en"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b1000, 0, "ld_step"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b1000, 0, "ld_hold"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0001, 1, "ld_step_tc"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, "ld_tc_drop"));
        // mode change overrides load and enable
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b0100, 4'b0100, 0, "mc_load"));
        vecs.push_back(mk(0, 1, 1, 0, 1, 4'b1111, 4'b0000, 0, "mc_to_john"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 4'b0000, 4'b0001, 0, "mc_john_up"));
        // reset overrides load/step; direction flip
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'b1110, 4'b1110, 0, "rs_load"));
        vecs.push_back(mk(1, 1, 1, 0, 1, 4'b0101, 4'b0000, 0, "rs_over_all"));
        vecs.push_back(mk(0, 1, 0, 0, 1, 4'b0100, 4'b0001, 0, "mc_to_ring"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0010, 0, "dir_up1"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b0000, 4'b0100, 0, "dir_up2"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 4'b0010, 0, "dir_flip"));
        vecs.push_back(mk(0, 1, 0, 1, 0, 4'b0000, 4'b0001, 1, "dir_dn_tc"));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].dir, vecs[i].load, vecs[i].lv);
            check({vecs[i].name, ".q"}, {28'd0, bus.Q}, {28'd0, vecs[i].exp_q});
            check({vecs[i].name, ".tc"}, {31'd0, bus.TC}, {31'd0, vecs[i].exp_tc});
            check_err(vecs[i].name, 1'b0);
        end

        // illegal ring pattern 0110
        drive(1, 0, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 0, 1, 4'b0110);
        check("ill_load.q", {28'd0, bus.Q}, 32'h6);
        check_err("ill_load", 1'b0);
        drive(0, 1, 0, 0, 0, 4'b0000);
`ifdef RING_ERR_DET_EN
        check("ill_step.q", {28'd0, bus.Q}, 32'h1);
        check_err("ill_step", 1'b1);
`else
        check("ill_step.q", {28'd0, bus.Q}, 32'hC);
`endif
        check("ill_step.tc", {31'd0, bus.TC}, 32'h0);
        drive(0, 1, 0, 0, 0, 4'b0000);
`ifdef RING_ERR_DET_EN
        check("ill_next.q", {28'd0, bus.Q}, 32'h2);
        check_err("ill_next", 1'b0);
`else
        check("ill_next.q", {28'd0, bus.Q}, 32'h9);
`endif
        check("ill_next.tc", {31'd0, bus.TC}, 32'h0);

        // ring all-zero state
        drive(0, 0, 0, 0, 1, 4'b0000);
`ifdef RING_ERR_DET_EN
        drive(0, 1, 0, 0, 0, 4'b0000);
        check("zero_rec.q", {28'd0, bus.Q}, 32'h1);
        check("zero_rec.tc", {31'd0, bus.TC}, 32'h0);
        check_err("zero_rec", 1'b1);
`else
        for (int i = 0; i < NB + 1; i++) begin
            drive(0, 1, 0, i[0], 0, 4'b0000);
            check("zero_stuck.q", {28'd0, bus.Q}, 32'h0);
            check("zero_stuck.tc", {31'd0, bus.TC}, 32'h0);
        end
`endif

        // Johnson period: two TC pulses in 4N steps, the last on the final step
        drive(1, 0, 1, 0, 0, 4'b0000);
        tc_count = 0;
        last_tc = -1;
        for (int i = 1; i <= 4 * NB; i++) begin
            drive(0, 1, 1, 0, 0, 4'b0000);
            if (bus.TC === 1'b1) begin
                tc_count++;
                last_tc = i;
            end
        end
        check("john_period.count", tc_count, 2);
        check("john_period.last", last_tc, 4 * NB);

        // randomized run against the model
        r_mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r_rst  = (i == 0) || ($urandom_range(0, 19) == 0);
            r_mode = ($urandom_range(0, 9) == 0) ? ~r_mode : r_mode;
            r_dir  = ($urandom_range(0, 7) == 0) ? ~r_dir : r_dir;
            if (i == 0) r_dir = 1'b0;
            r_load = ($urandom_range(0, 7) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_lv   = NB'($urandom_range(0, (1 << NB) - 1));
            model_step(r_rst, r_en, r_mode, r_dir, r_load, r_lv);
            drive(r_rst, r_en, r_mode, r_dir, r_load, r_lv);
            check("rand.q", {28'd0, bus.Q}, {28'd0, m_q});
            check("rand.tc", {31'd0, bus.TC}, {31'd0, m_tc});
`ifdef RING_ERR_DET_EN
            check("rand.err", {31'd0, bus.ERR}, {31'd0, m_err});
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
